// File: rtl/fpcmp_arb.sv
// fpcmp_arb: two-requester front end for one shared floating-point compare
// unit (fpcmp). Requests are granted round-robin; the winner's operands are
// latched and driven to the unit until it returns a result or the operation
// runs too long.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   req0/1, pred0/1          requester i has an operation pending, predicate
//   x0/y0, x1/y1             single-precision operands of requester i
//   done0/1                  one-cycle completion pulse of requester i
//   z0/1, flags0/1, err0/1   result, exception flags, timeout flag of requester i
//   cmp_run                  run request to fpcmp (high for the whole RUN phase)
//   cmp_stall                fpcmp busy; result valid when cmp_run & !cmp_stall
//   cmp_pred, cmp_x, cmp_y   latched operands for fpcmp
//   cmp_z, cmp_flags         fpcmp result
//   fsm_state                current controller state, for observation only
//
// Handshake: a requester raises req with pred/x/y stable and keeps them
// stable until its done pulse. The operands are latched at grant, so a req
// that drops mid-operation does not cancel it; done still pulses. A req
// still high after done is treated as a fresh operation with whatever
// operands are present in the following IDLE cycle.
module fpcmp_arb #(
    parameter int MAX_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [2:0]  pred0,
    input  logic [2:0]  pred1,
    input  logic [31:0] x0,
    input  logic [31:0] y0,
    input  logic [31:0] x1,
    input  logic [31:0] y1,
    output logic        done0,
    output logic        done1,
    output logic        z0,
    output logic        z1,
    output logic [4:0]  flags0,
    output logic [4:0]  flags1,
    output logic        err0,
    output logic        err1,
    output logic        cmp_run,
    input  logic        cmp_stall,
    output logic [2:0]  cmp_pred,
    output logic [31:0] cmp_x,
    output logic [31:0] cmp_y,
    input  logic        cmp_z,
    input  logic [4:0]  cmp_flags,
    output logic [1:0]  fsm_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [7:0] MAX_CNT = 8'(MAX_CYC);

    logic [1:0] state;
    logic       gnt;         // requester owning the current operation
    logic       last_grant;  // requester served most recently
    logic [7:0] cnt;         // RUN cycle number, 1 in the first RUN cycle
    logic       pick;

    // On a tie the requester that was not served last wins.
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = ~last_grant;
        end else if (req1) begin
            pick = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            gnt        <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= 8'd0;
            cmp_pred   <= 3'd0;
            cmp_x      <= 32'd0;
            cmp_y      <= 32'd0;
            z0         <= 1'b0;
            z1         <= 1'b0;
            flags0     <= 5'd0;
            flags1     <= 5'd0;
            err0       <= 1'b0;
            err1       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        gnt      <= pick;
                        cmp_pred <= pick ? pred1 : pred0;
                        cmp_x    <= pick ? x1 : x0;
                        cmp_y    <= pick ? y1 : y0;
                        cnt      <= 8'd1;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!cmp_stall) begin
                        if (gnt) begin
                            z1     <= cmp_z;
                            flags1 <= cmp_flags;
                            err1   <= 1'b0;
                        end else begin
                            z0     <= cmp_z;
                            flags0 <= cmp_flags;
                            err0   <= 1'b0;
                        end
                        state <= S_RESP;
                    end else if (cnt == MAX_CNT) begin
                        // Unit never answered: report a timeout with a
                        // cleared result.
                        if (gnt) begin
                            z1     <= 1'b0;
                            flags1 <= 5'd0;
                            err1   <= 1'b1;
                        end else begin
                            z0     <= 1'b0;
                            flags0 <= 5'd0;
                            err0   <= 1'b1;
                        end
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    last_grant <= gnt;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // RESP is a full cycle with cmp_run low, which also gives the unit its
    // mandatory gap between operations.
    assign cmp_run   = (state == S_RUN);
    assign done0     = (state == S_RESP) && !gnt;
    assign done1     = (state == S_RESP) && gnt;
    assign fsm_state = state;

endmodule

// File: tb/tb_fpcmp_arb.sv
// Bench for fpcmp_arb with a behavioural fpcmp stub. The stub stalls for
// x[2:0] RUN cycles and answers with a parity-based z and flags = y[8:4],
// so each operation's outcome is known when it is issued.
module tb_fpcmp_arb;

  localparam int MAX_CYC = 4;
  localparam int EXP_W   = 82;  // {z, flags[4:0], err, runs[7:0], pred[2:0], x, y}

  logic        clk;
  logic        rst;
  logic        req0, req1;
  logic [2:0]  pred0, pred1;
  logic [31:0] x0, y0, x1, y1;
  logic        done0, done1;
  logic        z0, z1;
  logic [4:0]  flags0, flags1;
  logic        err0, err1;
  logic        cmp_run;
  logic        cmp_stall;
  logic [2:0]  cmp_pred;
  logic [31:0] cmp_x, cmp_y;
  logic        cmp_z;
  logic [4:0]  cmp_flags;
  logic [1:0]  fsm_state;

  fpcmp_arb #(.MAX_CYC(MAX_CYC)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .pred0(pred0), .pred1(pred1),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .done0(done0), .done1(done1),
    .z0(z0), .z1(z1),
    .flags0(flags0), .flags1(flags1),
    .err0(err0), .err1(err1),
    .cmp_run(cmp_run), .cmp_stall(cmp_stall),
    .cmp_pred(cmp_pred), .cmp_x(cmp_x), .cmp_y(cmp_y),
    .cmp_z(cmp_z), .cmp_flags(cmp_flags),
    .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference functions ----------------
  function automatic logic ref_z(input logic [2:0] p, input logic [31:0] a, input logic [31:0] b);
    return ^{p, a, b};
  endfunction

  function automatic logic [4:0] ref_flags(input logic [31:0] b);
    return b[8:4];
  endfunction

  // Outcome of one operation: stall length k = x[2:0]; the unit answers
  // after k stalled cycles unless that reaches the RUN limit first.
  function automatic logic [EXP_W-1:0] model(input logic [2:0] p, input logic [31:0] a,
                                             input logic [31:0] b);
    int k;
    logic z;
    logic [4:0] f;
    logic e;
    logic [7:0] runs;
    k = int'(a[2:0]);
    if (k >= MAX_CYC) begin
      z = 1'b0; f = 5'd0; e = 1'b1; runs = 8'(MAX_CYC);
    end else begin
      z = ref_z(p, a, b); f = ref_flags(b); e = 1'b0; runs = 8'(k + 1);
    end
    return {z, f, e, runs, p, a, b};
  endfunction

  // ---------------- fpcmp stub ----------------
  int stub_cnt = 0;
  always @(posedge clk) begin
    if (cmp_run && cmp_stall) stub_cnt <= stub_cnt + 1;
    else stub_cnt <= 0;
  end
  assign cmp_stall = cmp_run && (stub_cnt < int'({29'd0, cmp_x[2:0]}));
  assign cmp_z     = ref_z(cmp_pred, cmp_x, cmp_y);
  assign cmp_flags = ref_flags(cmp_y);

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [EXP_W-1:0] exp0_q[$];
  logic [EXP_W-1:0] exp1_q[$];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int i, input logic [2:0] p, input logic [31:0] a, input logic [31:0] b);
    if (i == 0) begin
      exp0_q.push_back(model(p, a, b));
      pred0 = p; x0 = a; y0 = b; req0 = 1'b1;
    end else begin
      exp1_q.push_back(model(p, a, b));
      pred1 = p; x1 = a; y1 = b; req1 = 1'b1;
    end
  endtask

  task automatic release_req(input int i);
    if (i == 0) req0 = 1'b0;
    else req1 = 1'b0;
  endtask

  // Counts sampling points (one per cycle) from the issue cycle to the done pulse.
  task automatic wait_done(input int i, output int lat);
    logic got;
    got = 1'b0;
    lat = 0;
    while (!got && lat < 100) begin
      @(negedge clk);
      lat++;
      got = (i == 0) ? done0 : done1;
    end
    check($sformatf("done%0d_seen", i), got, 1'b1);
  endtask

  task automatic req_proc(input int i, input int n);
    logic kept;
    logic [31:0] a;
    int lat;
    kept = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (!kept) repeat ($urandom_range(1, 3)) step();
      a = $urandom;
      a[2:0] = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
      issue(i, 3'($urandom_range(0, 7)), a, $urandom);
      wait_done(i, lat);
      step();
      kept = 1'($urandom_range(0, 1));
      if (!kept) release_req(i);
    end
    release_req(i);
  endtask

  // ---------------- monitor ----------------
  logic             rst_prev = 1'b0;
  logic [6:0]       hold0 = '0;   // {z, flags, err} each requester must show
  logic [6:0]       hold1 = '0;
  int               run_cnt = 0;
  logic [66:0]      run_ops = '0;
  int               must_next = -1;
  logic [EXP_W-1:0] e;
  int               served;

  always @(negedge clk) begin
    if (rst_prev) begin
      hold0 = '0; hold1 = '0; run_cnt = 0; must_next = -1;
    end
    if (cmp_run) begin
      if (run_cnt == 0) run_ops = {cmp_pred, cmp_x, cmp_y};
      else check("opnd_stable", {cmp_pred, cmp_x, cmp_y}, run_ops);
      run_cnt++;
    end
    if (rst || rst_prev) begin
      check("no_done_in_rst", {done0, done1}, 2'b00);
    end else if (done0 || done1) begin
      check("done_both", done0 & done1, 1'b0);
      check("run_low_in_resp", cmp_run, 1'b0);
      served = done1 ? 1 : 0;
      if (must_next >= 0) check("rr_order", served, must_next);
      if (served == 0) begin
        check("done0_expected", exp0_q.size() > 0, 1'b1);
        if (exp0_q.size() > 0) begin
          e = exp0_q.pop_front();
          check("z0", z0, e[81]);
          check("flags0", flags0, e[80:76]);
          check("err0", err0, e[75]);
          hold0 = e[81:75];
        end
      end else begin
        check("done1_expected", exp1_q.size() > 0, 1'b1);
        if (exp1_q.size() > 0) begin
          e = exp1_q.pop_front();
          check("z1", z1, e[81]);
          check("flags1", flags1, e[80:76]);
          check("err1", err1, e[75]);
          hold1 = e[81:75];
        end
      end
      check("ops_at_done", {cmp_pred, cmp_x, cmp_y}, e[66:0]);
      check("run_cycles", run_cnt, e[74:67]);
      must_next = (served == 0) ? (req1 ? 1 : -1) : (req0 ? 0 : -1);
      run_cnt = 0;
    end
    if (!done0) check("hold0", {z0, flags0, err0}, hold0);
    if (!done1) check("hold1", {z1, flags1, err1}, hold1);
    rst_prev = rst;
  end

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    pred0 = '0; pred1 = '0; x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmp_run", cmp_run, 1'b0);
    check("rst_done0", done0, 1'b0);
    check("rst_done1", done1, 1'b0);
    check("rst_z0", z0, 1'b0);
    check("rst_z1", z1, 1'b0);
    check("rst_flags0", flags0, 5'd0);
    check("rst_flags1", flags1, 5'd0);
    check("rst_err0", err0, 1'b0);
    check("rst_err1", err1, 1'b0);
    check("rst_cmp_pred", cmp_pred, 3'd0);
    check("rst_cmp_x", cmp_x, 32'd0);
    check("rst_cmp_y", cmp_y, 32'd0);
    rst = 1'b0;

    // Single request, unit answers at once.
    issue(0, 3'b001, 32'h3F80_0000, 32'h4000_0000);
    wait_done(0, lat);
    check("lat_single", lat, 3);
    check("z0_single", z0, 1'b1);
    check("flags0_single", flags0, 5'd0);
    check("err0_single", err0, 1'b0);
    step(); release_req(0);

    // Three stalled cycles, then a flagged answer.
    step();
    issue(1, 3'b010, 32'h1234_5673, 32'h0000_0100);
    wait_done(1, lat);
    check("lat_stall3", lat, 6);
    check("flags1_stall3", flags1, 5'b10000);
    step(); release_req(1);

    // Stuck unit times out; the next operation clears the error.
    step();
    issue(1, 3'b100, 32'hC000_0005, 32'h0000_01F0);
    wait_done(1, lat);
    check("lat_timeout", lat, 2 + MAX_CYC);
    check("err1_timeout", err1, 1'b1);
    check("z1_timeout", z1, 1'b0);
    check("flags1_timeout", flags1, 5'd0);
    step();
    issue(1, 3'b001, 32'h3F80_0000, 32'h4000_0000);
    wait_done(1, lat);
    check("lat_after_timeout", lat, 3);
    check("err1_cleared", err1, 1'b0);
    step(); release_req(1);

    // Both requesters rise together and hold for two operations each.
    step();
    issue(0, 3'b011, 32'h0000_0010, 32'h0000_0050);
    issue(1, 3'b110, 32'h0000_0020, 32'h0000_0060);
    exp0_q.push_back(model(3'b011, 32'h0000_0010, 32'h0000_0050));
    exp1_q.push_back(model(3'b110, 32'h0000_0020, 32'h0000_0060));
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      check($sformatf("tie_done0_c%0d", c), done0, (c == 3 || c == 9));
      check($sformatf("tie_done1_c%0d", c), done1, (c == 6 || c == 12));
      check($sformatf("tie_run_c%0d", c), cmp_run, (c % 3 == 2));
      step();
      if (c == 9) release_req(0);
      if (c == 12) release_req(1);
    end

    // Randomized concurrent traffic.
    fork
      req_proc(0, 40);
      req_proc(1, 40);
    join

    // Reset in the second RUN cycle, then both requesters pending.
    step();
    issue(0, 3'b011, 32'h0000_0007, 32'h0000_0001);
    step();
    step();
    rst = 1'b1;
    void'(exp0_q.pop_back());
    issue(0, 3'b101, 32'h4040_0000, 32'h0000_0230);
    issue(1, 3'b110, 32'hBF80_0000, 32'h0000_0000);
    step();
    @(negedge clk);
    check("rst_abort_cmp_run", cmp_run, 1'b0);
    check("rst_abort_done", {done0, done1}, 2'b00);
    check("rst_abort_cmp_x", cmp_x, 32'd0);
    step();
    rst = 1'b0;
    wait_done(0, lat);
    check("lat_post_rst_req0", lat, 3);
    step(); release_req(0);
    wait_done(1, lat);
    check("lat_post_rst_req1", lat, 3);
    step(); release_req(1);

    repeat (5) step();
    check("exp0_drained", exp0_q.size(), 0);
    check("exp1_drained", exp1_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fpcmp_arb.md
FPCMP_ARB -- requirements
Module: fpcmp_arb

Interface
REQ-001 Parameter: MAX_CYC, default 255, max RUN cycles (1..255) before an operation is aborted with error.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0, req1  input  1 each  requester i has a compare operation pending.
REQ-005 pred0, pred1  input  3 each  predicate of requester i; stable while req i high.
REQ-006 x0, y0, x1, y1  input  32 each  single-precision operands of requester i; stable while req i high.
REQ-007 done0, done1  output  1 each  one-cycle pulse: operation of requester i complete.
REQ-008 z0, z1  output  1 each  compare result of requester i.
REQ-009 flags0, flags1  output  5 each  exception flags of requester i.
REQ-010 err0, err1  output  1 each  requester i's last operation timed out.
REQ-011 cmp_run  output  1  run request to the shared fpcmp unit.
REQ-012 cmp_stall  input  1  fpcmp busy; result valid in a cmp_run cycle with cmp_stall low.
REQ-013 cmp_pred, cmp_x, cmp_y  output  3/32/32  operands to fpcmp.
REQ-014 cmp_z, cmp_flags  input  1/5  fpcmp result.

Function
REQ-015 States: IDLE, RUN, RESP; no other reachable states; any illegal encoding goes to IDLE next cycle.
REQ-016 IDLE: cmp_run=0; if no req, stay; if req(s) high, grant and go RUN next cycle.
REQ-017 Arbitration: only one req high -> grant it; both high -> grant the requester not granted last (round-robin via last_grant register).
REQ-018 At grant, pred/x/y of the granted requester are captured into operand registers driving cmp_pred/cmp_x/cmp_y, held unchanged until next grant.
REQ-019 RUN: cmp_run=1; 8-bit cycle counter = 1 in first RUN cycle, +1 each further RUN cycle.
REQ-020 RUN with cmp_stall=0: capture cmp_z/cmp_flags into granted requester's z/flags, clear its err, go RESP.
REQ-021 RUN with cmp_stall=1 and counter==MAX_CYC: set granted err=1, z=0, flags=0, go RESP; otherwise stay in RUN.
REQ-022 RESP: cmp_run=0; granted done=1 for exactly this cycle; update last_grant; go IDLE.
REQ-023 Minimum latency: req sampled in IDLE cycle n -> RUN cycle n+1 -> done in cycle n+2; cmp_stall high for k RUN cycles adds k cycles.
REQ-024 z/flags/err of a requester change only on its own completion; held stable otherwise, including while the other requester is served.
REQ-025 cmp_run is low for at least one cycle (RESP) between consecutive operations.
REQ-026 A requester keeping req high after done starts a new operation with the operands present in the following IDLE cycle.
REQ-027 req of the granted requester dropping during RUN/RESP is ignored; the operation completes and done pulses.
REQ-028 Non-granted req is never lost; it is served no later than the next grant.

Reset
REQ-029 rst high: state=IDLE, cmp_run=0, done0=done1=0, z0=z1=0, flags0=flags1=0, err0=err1=0, operand registers=0, counter=0, last_grant=1 (req0 wins first tie).
REQ-030 rst during RUN or RESP aborts the operation: no done pulse, no result update; cmp_run=0 in the cycle after rst is sampled.

Verification
REQ-031 req0, pred=3'b001, x=0x3F800000, y=0x40000000, stub cmp_stall=0, cmp_z=1, cmp_flags=0 -> done0 in cycle n+2, z0=1, flags0=0, err0=0, done1 never.
REQ-032 req0 and req1 rising same cycle, held high -> grants 0,1,0,1; done0/done1 alternate every 3 cycles; cmp_run low one cycle between ops.
REQ-033 cmp_stall high 3 RUN cycles then low, cmp_flags=5'b10000 -> cmp_run high 4 cycles, cmp_x/cmp_y constant throughout, flags1=5'b10000 after done1.
REQ-034 MAX_CYC=4, cmp_stall stuck high on req1 -> after 4 RUN cycles done1 pulses, err1=1, z1=0, flags1=0; next req1 with normal stall clears err1.
REQ-035 rst asserted in second RUN cycle, then both reqs high -> no done during/after reset, cmp_run=0 cycle after rst, req0 granted first, all outputs at reset values until first done.
